// File: rtl/arq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arq_pkg
// Description : ARQ frame sender state encoding and width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_REPLAY   = 2'd3
    } arq_state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int min1_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arq_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : arq_frame_buf
// Description : Frame copy store; synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module arq_frame_buf #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [FRAME_LEN];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/arq_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : arq_frame_sender
// Description : Forwards mapper frames to the line, replays on NACK/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module arq_frame_sender
    import arq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FRAME_LEN   = 64,
    parameter int MAX_RETRIES = 3,
    parameter int ACK_TIMEOUT = 4096,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_arq_en,
    input  logic [DATA_W-1:0] i_frame_data,
    input  logic              i_frame_data_valid,
    input  logic              i_frame_data_fas,
    output logic              o_frame_data_ready,
    output logic [DATA_W-1:0] o_line_data,
    output logic              o_line_data_valid,
    input  logic              i_line_data_ready,
    input  logic              i_ack_valid,
    input  logic              i_ack_good,
    output logic              o_busy,
    output logic              o_send_complete,
    output logic              o_frame_drop,
    output logic [CNT_W-1:0]  o_retrans_cnt
);

    localparam int c_PTR_W = min1_clog2(FRAME_LEN);
    localparam int c_TMR_W = min1_clog2(ACK_TIMEOUT);
    localparam int c_RTY_W = min1_clog2(MAX_RETRIES + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FRAME_LEN - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRIES);

    arq_state_t          r_state;
    arq_state_t          w_state_nxt;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_RTY_W-1:0]  r_retry;
    logic                r_arq_mode;
    logic [CNT_W-1:0]    r_retrans_cnt;
    logic                r_send_complete;
    logic                r_frame_drop;

    logic                w_frame_ready;
    logic                w_line_valid;
    logic [DATA_W-1:0]   w_line_data;
    logic                w_buf_we;
    logic [c_PTR_W-1:0]  w_buf_waddr;
    logic [DATA_W-1:0]   w_buf_rdata;
    logic                w_line_xfer;
    logic                w_fill_last;
    logic                w_complete_evt;
    logic                w_drop_evt;
    logic                w_retry_evt;

    arq_frame_buf #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (c_PTR_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_buf_we),
        .i_wr_addr (w_buf_waddr),
        .i_wr_data (i_frame_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_buf_rdata)
    );

    assign w_buf_waddr = (r_state == ST_IDLE) ? '0 : r_wr_ptr;
    assign w_line_xfer = w_line_valid & i_line_data_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_frame_ready  = 1'b0;
        w_line_valid   = 1'b0;
        w_line_data    = '0;
        w_buf_we       = 1'b0;
        w_fill_last    = 1'b0;
        w_complete_evt = 1'b0;
        w_drop_evt     = 1'b0;
        w_retry_evt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only a FAS byte may open a frame; anything else is flushed.
                if (i_frame_data_fas) begin
                    w_line_data   = i_frame_data;
                    w_line_valid  = i_frame_data_valid;
                    w_frame_ready = i_line_data_ready;
                    w_buf_we      = i_frame_data_valid & i_line_data_ready;
                end else begin
                    w_frame_ready = 1'b1;
                end
                if (w_buf_we) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_line_data   = i_frame_data;
                w_line_valid  = i_frame_data_valid;
                w_frame_ready = i_line_data_ready;
                w_buf_we      = i_frame_data_valid & i_line_data_ready;
                w_fill_last   = w_buf_we & (r_wr_ptr == c_PTR_LAST);
                if (w_fill_last) begin
                    w_state_nxt    = r_arq_mode ? ST_WAIT_ACK : ST_IDLE;
                    w_complete_evt = ~r_arq_mode;
                end
            end
            ST_WAIT_ACK: begin
                if (i_ack_valid & i_ack_good) begin
                    w_state_nxt    = ST_IDLE;
                    w_complete_evt = 1'b1;
                end else if (i_ack_valid | (r_timer == c_TMR_LAST)) begin
                    if (r_retry == c_RTY_MAX) begin
                        w_state_nxt = ST_IDLE;
                        w_drop_evt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_REPLAY;
                        w_retry_evt = 1'b1;
                    end
                end
            end
            ST_REPLAY: begin
                w_line_data  = w_buf_rdata;
                w_line_valid = 1'b1;
                if (w_line_xfer && (r_rd_ptr == c_PTR_LAST)) begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_timer         <= '0;
            r_retry         <= '0;
            r_arq_mode      <= 1'b0;
            r_retrans_cnt   <= '0;
            r_send_complete <= 1'b0;
            r_frame_drop    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_send_complete <= w_complete_evt;
            r_frame_drop    <= w_drop_evt;
            case (r_state)
                ST_IDLE: begin
                    if (w_buf_we) begin
                        r_wr_ptr   <= c_PTR_W'(1);
                        r_arq_mode <= i_arq_en;
                    end
                end
                ST_FILL: begin
                    if (w_fill_last) begin
                        r_wr_ptr <= '0;
                        r_timer  <= '0;
                        r_retry  <= '0;
                    end else if (w_buf_we) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    r_timer <= r_timer + c_TMR_W'(1);
                    if (w_retry_evt) begin
                        r_retry  <= r_retry + c_RTY_W'(1);
                        r_rd_ptr <= '0;
                        if (r_retrans_cnt != {CNT_W{1'b1}}) begin
                            r_retrans_cnt <= r_retrans_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_REPLAY: begin
                    if (w_line_xfer) begin
                        if (r_rd_ptr == c_PTR_LAST) begin
                            r_rd_ptr <= '0;
                            r_timer  <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                        end
                    end
                end
                default: begin
                    r_wr_ptr <= '0;
                end
            endcase
        end
    end

    // Reset forces the line side quiet even though the datapath is combinational.
    assign o_frame_data_ready = w_frame_ready & ~i_rst;
    assign o_line_data_valid  = w_line_valid & ~i_rst;
    assign o_line_data        = i_rst ? '0 : w_line_data;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_send_complete    = r_send_complete;
    assign o_frame_drop       = r_frame_drop;
    assign o_retrans_cnt      = r_retrans_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arq_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_arq_frame_sender
// Description : Self-checking bench for arq_frame_sender (FRAME_LEN=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arq_frame_sender;

    localparam int DW = 8;
    localparam int FL = 8;
    localparam int MR = 2;
    localparam int TO = 32;
    localparam int CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_arq_en;
    logic [DW-1:0] i_frame_data;
    logic          i_frame_data_valid;
    logic          i_frame_data_fas;
    logic          o_frame_data_ready;
    logic [DW-1:0] o_line_data;
    logic          o_line_data_valid;
    logic          i_line_data_ready;
    logic          i_ack_valid;
    logic          i_ack_good;
    logic          o_busy;
    logic          o_send_complete;
    logic          o_frame_drop;
    logic [CW-1:0] o_retrans_cnt;

    always #5 i_clk = ~i_clk;

    arq_frame_sender #(
        .DATA_W(DW), .FRAME_LEN(FL), .MAX_RETRIES(MR), .ACK_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_arq_en(i_arq_en),
        .i_frame_data(i_frame_data), .i_frame_data_valid(i_frame_data_valid),
        .i_frame_data_fas(i_frame_data_fas), .o_frame_data_ready(o_frame_data_ready),
        .o_line_data(o_line_data), .o_line_data_valid(o_line_data_valid),
        .i_line_data_ready(i_line_data_ready), .i_ack_valid(i_ack_valid),
        .i_ack_good(i_ack_good), .o_busy(o_busy), .o_send_complete(o_send_complete),
        .o_frame_drop(o_frame_drop), .o_retrans_cnt(o_retrans_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          bp_en    = 1'b0;
    int          stalls   = 0;
    int          exp_retrans = 0;
    logic [7:0]  frm [FL];
    logic [7:0]  line_q [$];
    logic [7:0]  exp_q [$];
    int          line_st [$];
    int          up_st [$];
    int          comp_st [$];
    int          drop_st [$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_line_data_valid && i_line_data_ready) begin
            line_q.push_back(o_line_data);
            line_st.push_back(cyc);
        end
        if (i_frame_data_valid && o_frame_data_ready) up_st.push_back(cyc);
        if (o_send_complete) comp_st.push_back(cyc);
        if (o_frame_drop) drop_st.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_line_data_ready = bp_en ? ~i_line_data_ready : 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        line_q.delete(); exp_q.delete(); line_st.delete();
        up_st.delete(); comp_st.delete(); drop_st.delete();
        stalls = 0;
    endtask

    task automatic new_frame(input bit fixed);
        for (int i = 0; i < FL; i++) frm[i] = fixed ? 8'(8'h11 + i) : 8'($urandom);
    endtask

    task automatic expect_frame(input int copies);
        for (int c = 0; c < copies; c++)
            for (int i = 0; i < FL; i++) exp_q.push_back(frm[i]);
    endtask

    // Offer one byte until the block takes it; returns right after the transfer edge.
    task automatic offer_byte(input logic [7:0] b, input logic fas);
        bit hs = 1'b0;
        int t  = 0;
        i_frame_data       = b;
        i_frame_data_valid = 1'b1;
        i_frame_data_fas   = fas;
        while (!hs && t < 200) begin
            @(negedge i_clk);
            hs = o_frame_data_ready;
            tick();
            t++;
        end
        if (!hs) stalls++;
        i_frame_data_valid = 1'b0;
        i_frame_data_fas   = 1'b0;
    endtask

    // i_arq_en is scrambled after the FAS byte; only its value at the FAS counts.
    task automatic drive_frame(input logic arq);
        for (int i = 0; i < FL; i++) begin
            i_arq_en = (i == 0) ? arq : 1'($urandom);
            offer_byte(frm[i], i == 0);
        end
        i_arq_en = 1'($urandom);
    endtask

    task automatic send_ack(input logic good);
        i_ack_valid = 1'b1;
        i_ack_good  = good;
        tick();
        i_ack_valid = 1'b0;
        i_ack_good  = 1'($urandom);
    endtask

    task automatic wait_line(input int n);
        int t = 0;
        while (line_q.size() < n && t < 2000) begin
            tick();
            t++;
        end
    endtask

    function automatic int first_diff();
        if (line_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (line_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        i_rst = 1'b1; i_arq_en = 1'b0; i_frame_data = 8'h5A;
        i_frame_data_valid = 1'b1; i_frame_data_fas = 1'b1;
        i_line_data_ready = 1'b1; i_ack_valid = 1'b0; i_ack_good = 1'b0;
        wait_cycles(2);
        @(negedge i_clk);
        n_checks++;
        if ({o_line_data_valid, o_frame_data_ready, o_line_data} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b ready=%0b data=%h, required 0/0/00",
                     o_line_data_valid, o_frame_data_ready, o_line_data);
        end
        tick();
        i_frame_data_valid = 1'b0; i_frame_data_fas = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if ({o_busy, o_send_complete, o_frame_drop} !== 3'b000 || o_retrans_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b comp=%0b drop=%0b cnt=%0d, required all 0",
                     o_busy, o_send_complete, o_frame_drop, o_retrans_cnt);
        end
        tick();
    endtask

    task automatic test_passthrough();
        int bad = 0;
        int d;
        clear_mon();
        new_frame(1'b1);
        drive_frame(1'b0);
        wait_cycles(5);
        expect_frame(1);
        d = first_diff();
        n_checks++;
        if (d != -1 || stalls != 0) begin
            n_fail++;
            $display("FAIL pt_data: diff_at=%0d got_len=%0d stalls=%0d, required len=%0d",
                     d, line_q.size(), stalls, exp_q.size());
        end
        if (up_st.size() != line_st.size()) bad++;
        else foreach (up_st[i]) if (up_st[i] != line_st[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL pt_latency: %0d byte(s) not on line in their accept cycle, required 0", bad);
        end
        n_checks++;
        if (comp_st.size() != 1 || comp_st[0] != up_st[FL-1] + 1 || drop_st.size() != 0) begin
            n_fail++;
            $display("FAIL pt_complete: pulses=%0d drops=%0d, required 1 pulse one cycle after last byte",
                     comp_st.size(), drop_st.size());
        end
    endtask

    task automatic test_arq_ack();
        int d;
        clear_mon();
        new_frame(1'b1);
        drive_frame(1'b1);
        wait_cycles(9);
        send_ack(1'b1);
        wait_cycles(3);
        n_checks++;
        if (comp_st.size() != 1 || o_retrans_cnt !== 16'(exp_retrans) || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_single: pulses=%0d cnt=%0d busy=%0b, required 1/%0d/0",
                     comp_st.size(), o_retrans_cnt, o_busy, exp_retrans);
        end
        expect_frame(1);
        new_frame(1'b0);
        drive_frame(1'b0);
        wait_cycles(3);
        expect_frame(1);
        d = first_diff();
        n_checks++;
        if (d != -1 || comp_st.size() != 2) begin
            n_fail++;
            $display("FAIL ack_next_frame: diff_at=%0d pulses=%0d, required -1/2", d, comp_st.size());
        end
    endtask

    task automatic test_nack_then_ack();
        int d;
        clear_mon();
        new_frame(1'b1);
        drive_frame(1'b1);
        wait_cycles(3);
        send_ack(1'b0);
        wait_line(2 * FL);
        wait_cycles(2);
        send_ack(1'b1);
        wait_cycles(3);
        exp_retrans += 1;
        expect_frame(2);
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL nack_data: diff_at=%0d got_len=%0d, required len=%0d", d, line_q.size(), 2 * FL);
        end
        n_checks++;
        if (o_retrans_cnt !== 16'(exp_retrans) || comp_st.size() != 1 || drop_st.size() != 0) begin
            n_fail++;
            $display("FAIL nack_counts: cnt=%0d pulses=%0d drops=%0d, required %0d/1/0",
                     o_retrans_cnt, comp_st.size(), drop_st.size(), exp_retrans);
        end
    endtask

    task automatic test_timeout_drop();
        int d;
        int g1, g2, gd;
        clear_mon();
        new_frame(1'b0);
        drive_frame(1'b1);
        wait_line(3 * FL);
        wait_cycles(TO + 8);
        exp_retrans += MR;
        expect_frame(MR + 1);
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL to_data: diff_at=%0d got_len=%0d, required len=%0d", d, line_q.size(), exp_q.size());
        end
        g1 = (line_st.size() > 2 * FL) ? line_st[FL] - line_st[FL-1] : -1;
        g2 = (line_st.size() > 2 * FL) ? line_st[2*FL] - line_st[2*FL-1] : -1;
        n_checks++;
        if (g1 != TO + 1 || g2 != TO + 1) begin
            n_fail++;
            $display("FAIL to_gap: gaps=%0d,%0d, required %0d", g1, g2, TO + 1);
        end
        gd = (drop_st.size() == 1 && line_st.size() == 3 * FL) ? drop_st[0] - line_st[3*FL-1] : -1;
        n_checks++;
        if (gd != TO + 1 || comp_st.size() != 0) begin
            n_fail++;
            $display("FAIL to_drop: drops=%0d delay=%0d pulses=%0d, required 1/%0d/0",
                     drop_st.size(), gd, comp_st.size(), TO + 1);
        end
        n_checks++;
        if (o_retrans_cnt !== 16'(exp_retrans) || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_cnt: cnt=%0d busy=%0b, required %0d/0", o_retrans_cnt, o_busy, exp_retrans);
        end
    endtask

    task automatic test_backpressure_resync();
        int d;
        clear_mon();
        bp_en = 1'b1;
        offer_byte(8'hAA, 1'b0);
        offer_byte(8'hBB, 1'b0);
        new_frame(1'b0);
        drive_frame(1'b1);
        wait_cycles(4);
        send_ack(1'b0);
        wait_line(2 * FL);
        wait_cycles(2);
        send_ack(1'b1);
        wait_cycles(3);
        bp_en = 1'b0;
        exp_retrans += 1;
        expect_frame(2);
        d = first_diff();
        n_checks++;
        if (d != -1 || stalls != 0) begin
            n_fail++;
            $display("FAIL bp_data: diff_at=%0d got_len=%0d stalls=%0d, required len=%0d",
                     d, line_q.size(), stalls, 2 * FL);
        end
        n_checks++;
        if (comp_st.size() != 1 || o_retrans_cnt !== 16'(exp_retrans)) begin
            n_fail++;
            $display("FAIL bp_counts: pulses=%0d cnt=%0d, required 1/%0d",
                     comp_st.size(), o_retrans_cnt, exp_retrans);
        end
    endtask

    task automatic test_ack_at_timeout();
        int dl;
        clear_mon();
        new_frame(1'b0);
        drive_frame(1'b1);
        wait_cycles(TO - 1);
        send_ack(1'b1);
        wait_cycles(TO + 8);
        dl = (comp_st.size() == 1 && line_st.size() >= FL) ? comp_st[0] - line_st[FL-1] : -1;
        n_checks++;
        if (line_q.size() != FL || dl != TO + 1 || drop_st.size() != 0
            || o_retrans_cnt !== 16'(exp_retrans)) begin
            n_fail++;
            $display("FAIL ack_timeout: line_len=%0d comp_delay=%0d drops=%0d cnt=%0d, required %0d/%0d/0/%0d",
                     line_q.size(), dl, drop_st.size(), o_retrans_cnt, FL, TO + 1, exp_retrans);
        end
    endtask

    task automatic test_reset_mid_replay();
        clear_mon();
        new_frame(1'b0);
        drive_frame(1'b1);
        wait_cycles(2);
        send_ack(1'b0);
        wait_line(FL + 4);
        i_rst = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_line_data_valid !== 1'b0 || o_line_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_replay_gate: valid=%0b data=%h, required 0/00", o_line_data_valid, o_line_data);
        end
        tick();
        i_rst = 1'b0;
        exp_retrans = 0;
        @(negedge i_clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_line_data_valid !== 1'b0 || o_retrans_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_replay_state: busy=%0b valid=%0b cnt=%0d, required 0/0/0",
                     o_busy, o_line_data_valid, o_retrans_cnt);
        end
        wait_cycles(TO + 8);
        n_checks++;
        if (comp_st.size() != 0 || drop_st.size() != 0 || line_q.size() != FL + 4) begin
            n_fail++;
            $display("FAIL rst_replay_quiet: pulses=%0d drops=%0d line_len=%0d, required 0/0/%0d",
                     comp_st.size(), drop_st.size(), line_q.size(), FL + 4);
        end
    endtask

    // Random frames with random NACK counts; the model counts bursts and outcomes.
    task automatic test_random();
        int d;
        int exp_comp = 0;
        int exp_drop = 0;
        clear_mon();
        for (int f = 0; f < 6; f++) begin
            logic arq = 1'($urandom);
            int   k   = $urandom_range(0, MR + 1);
            int   nb  = arq ? ((k < MR ? k : MR) + 1) : 1;
            int   base = exp_q.size();
            bp_en = 1'($urandom);
            new_frame(1'b0);
            drive_frame(arq);
            expect_frame(nb);
            if (arq) begin
                for (int j = 0; j < nb; j++) begin
                    wait_line(base + FL * (j + 1));
                    wait_cycles($urandom_range(1, 20));
                    send_ack(j < k ? 1'b0 : 1'b1);
                end
                exp_retrans += nb - 1;
                if (k > MR) exp_drop++; else exp_comp++;
            end else begin
                exp_comp++;
            end
            wait_cycles(4);
        end
        bp_en = 1'b0;
        wait_cycles(2);
        d = first_diff();
        n_checks++;
        if (d != -1 || stalls != 0) begin
            n_fail++;
            $display("FAIL rand_data: diff_at=%0d got_len=%0d stalls=%0d, required len=%0d",
                     d, line_q.size(), stalls, exp_q.size());
        end
        n_checks++;
        if (comp_st.size() != exp_comp || drop_st.size() != exp_drop
            || o_retrans_cnt !== 16'(exp_retrans)) begin
            n_fail++;
            $display("FAIL rand_counts: pulses=%0d drops=%0d cnt=%0d, required %0d/%0d/%0d",
                     comp_st.size(), drop_st.size(), o_retrans_cnt, exp_comp, exp_drop, exp_retrans);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_arq_ack();
        test_nack_then_ack();
        test_timeout_drop();
        test_backpressure_resync();
        test_ack_at_timeout();
        test_random();
        test_reset_mid_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
